// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: sequences core accesses onto a single-ported data-memory/IO bus,
// with sub-doubleword stores done as read-modify-write and loads extracted/extended per size.
module lsu_bus_master #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [12:0] req_addr,
  input  logic [2:0]  req_offset,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [12:0] direccion,
  output logic [63:0] dataWrite,
  output logic        memWr,
  input  logic [63:0] dataRead
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic        q_we, q_signed;
  logic [12:0] q_addr;
  logic [2:0]  q_off;
  logic [1:0]  q_size;
  logic [63:0] q_wdata;
  logic [12:0] direccion_n;
  logic [63:0] datawrite_n, rdata_n;
  logic        memwr_n, rvalid_n, err_n;

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] data, input logic [2:0] off,
                                          input logic [1:0] size, input logic sgn);
    logic signed [63:0] sh;
    sh = $signed(data >> {off, 3'b000});
    case (size)
      2'd0:    return sgn ? 64'(sh[7:0]  ) | {{56{sh[7]}},  8'd0} : {56'd0, sh[7:0]};
      2'd1:    return sgn ? 64'(sh[15:0] ) | {{48{sh[15]}}, 16'd0} : {48'd0, sh[15:0]};
      2'd2:    return sgn ? 64'(sh[31:0] ) | {{32{sh[31]}}, 32'd0} : {32'd0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wdata,
                                        input logic [2:0] off, input logic [1:0] size);
    logic [7:0]  bm;
    logic [63:0] ws, m;
    case (size)
      2'd0:    bm = 8'h01;
      2'd1:    bm = 8'h03;
      2'd2:    bm = 8'h0F;
      default: bm = 8'hFF;
    endcase
    bm = bm << off;
    ws = wdata << {off, 3'b000};
    for (int i = 0; i < 8; i++) m[8*i +: 8] = bm[i] ? ws[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction

  assign req_ready = (state == IDLE);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    direccion_n = direccion;
    datawrite_n = dataWrite;
    memwr_n     = 1'b0;
    rvalid_n    = 1'b0;
    rdata_n     = 64'd0;
    err_n       = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        if (misaligned(req_offset, req_size)) begin
          state_n  = RESP;
          rvalid_n = 1'b1;
          err_n    = 1'b1;
        end else if (req_we && (req_size == 2'd3 || req_addr[12])) begin
          // Full doublewords and IO registers need no merge; IO data stays unshifted
          state_n     = WRITE;
          direccion_n = req_addr;
          datawrite_n = req_wdata;
          memwr_n     = 1'b1;
          rvalid_n    = 1'b1;
        end else begin
          state_n     = READ;
          direccion_n = req_addr;
          cnt_n       = 2'd0;
        end
      end
      READ: begin
        if (cnt == 2'(READ_LAT - 1)) begin
          rvalid_n = 1'b1;
          if (q_we) begin
            state_n     = WRITE;
            datawrite_n = merge(dataRead, q_wdata, q_off, q_size);
            memwr_n     = 1'b1;
          end else begin
            state_n = RESP;
            rdata_n = extract(dataRead, q_addr[12] ? 3'd0 : q_off, q_size, q_signed);
          end
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      direccion  <= 13'd0;
      dataWrite  <= 64'd0;
      memWr      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      direccion  <= direccion_n;
      dataWrite  <= datawrite_n;
      memWr      <= memwr_n;
      resp_valid <= rvalid_n;
      resp_rdata <= rdata_n;
      resp_err   <= err_n;
    end
  end

  // Request capture at acceptance; later input changes are ignored
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      q_we     <= req_we;
      q_addr   <= req_addr;
      q_off    <= req_offset;
      q_size   <= req_size;
      q_signed <= req_signed;
      q_wdata  <= req_wdata;
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: a READ_LAT=1 instance against a small memory/IO model,
// plus a READ_LAT=3 instance reading the same memory to check load latency.
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [12:0] req_addr;
  logic [2:0]  req_offset;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        resp_valid, resp_err, memWr;
  logic [63:0] resp_rdata, dataWrite, dataRead;
  logic [12:0] direccion;

  logic        b_valid, b_ready, b_we, b_signed;
  logic [12:0] b_addr;
  logic [2:0]  b_offset;
  logic [1:0]  b_size;
  logic [63:0] b_wdata;
  logic        b_rvalid, b_err, b_memwr;
  logic [63:0] b_rdata, b_dwrite, b_dread;
  logic [12:0] b_dir;

  logic [63:0] mem [0:255];
  logic [7:0]  sw;
  int          wr_pulses = 0;
  int          passed = 0, total = 0, failed = 0;

  always #5 clk = ~clk;

  lsu_bus_master #(.READ_LAT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_offset(req_offset), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .direccion(direccion), .dataWrite(dataWrite), .memWr(memWr), .dataRead(dataRead)
  );

  lsu_bus_master #(.READ_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_offset(b_offset), .req_size(b_size), .req_signed(b_signed),
    .req_wdata(b_wdata), .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err),
    .direccion(b_dir), .dataWrite(b_dwrite), .memWr(b_memwr), .dataRead(b_dread)
  );

  assign dataRead = direccion[12] ? {56'd0, sw} : mem[direccion[7:0]];
  assign b_dread  = mem[b_dir[7:0]];

  always @(posedge clk) begin
    if (memWr === 1'b1) begin
      wr_pulses <= wr_pulses + 1;
      if (!direccion[12]) mem[direccion[7:0]] <= dataWrite;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one access, take the acceptance edge, then scramble the inputs
  task automatic present(input logic we, input logic [12:0] addr, input logic [2:0] off,
                         input logic [1:0] size, input logic sgn, input logic [63:0] wdata);
    req_we = we; req_addr = addr; req_offset = off; req_size = size;
    req_signed = sgn; req_wdata = wdata; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_we = ~we; req_addr = 13'h0AA; req_offset = 3'd5;
    req_size = 2'd2; req_signed = ~sgn; req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
  endtask

  task automatic load_chk(input string tag, input logic [12:0] addr, input logic [2:0] off,
                          input logic [1:0] size, input logic sgn, input logic [63:0] exp);
    present(1'b0, addr, off, size, sgn, 64'd0);
    chk({tag, " read-phase valid"}, 64'(resp_valid), 64'd0);
    chk({tag, " addr"}, 64'(direccion), 64'(addr));
    tick();
    chk({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, " rdata"}, resp_rdata, exp);
    chk({tag, " err"}, 64'(resp_err), 64'd0);
    tick();
    chk({tag, " idle"}, {62'd0, resp_valid, req_ready}, 64'd1);
  endtask

  initial begin
    int p0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_offset = '0;
    req_size = '0; req_signed = 1'b0; req_wdata = '0; sw = 8'h5A;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_offset = '0; b_size = '0;
    b_signed = 1'b0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset dir", 64'(direccion), 64'd0);
    chk("reset dwrite", dataWrite, 64'd0);
    chk("reset ctl", {59'd0, memWr, resp_valid, resp_err, req_ready, |resp_rdata}, 64'h2);

    // Doubleword store then load back
    present(1'b1, 13'h005, 3'd0, 2'd3, 1'b0, 64'h1122334455667788);
    chk("dw st memWr", 64'(memWr), 64'd1);
    chk("dw st dir", 64'(direccion), 64'h005);
    chk("dw st data", dataWrite, 64'h1122334455667788);
    chk("dw st resp", {62'd0, resp_valid, req_ready}, 64'h2);
    chk("dw st rdata", resp_rdata, 64'd0);
    tick();
    chk("dw st end", {62'd0, memWr, resp_valid}, 64'd0);
    chk("dw st hold dir", 64'(direccion), 64'h005);
    load_chk("dw ld", 13'h005, 3'd0, 2'd3, 1'b0, 64'h1122334455667788);

    present(1'b1, 13'h010, 3'd0, 2'd3, 1'b0, 64'h00000000000080FF);
    tick();
    load_chk("byte0 s", 13'h010, 3'd0, 2'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF);
    load_chk("half0 u", 13'h010, 3'd0, 2'd1, 1'b0, 64'h00000000000080FF);
    load_chk("byte1 s", 13'h010, 3'd1, 2'd0, 1'b1, 64'hFFFFFFFFFFFFFF80);
    load_chk("word0 s", 13'h010, 3'd0, 2'd2, 1'b1, 64'h00000000000080FF);

    // Sub-doubleword RMW store
    p0 = wr_pulses;
    present(1'b1, 13'h010, 3'd3, 2'd0, 1'b0, 64'h00000000000000AB);
    chk("rmw read phase", {62'd0, memWr, resp_valid}, 64'd0);
    tick();
    chk("rmw memWr", {62'd0, memWr, resp_valid}, 64'h3);
    chk("rmw data", dataWrite, 64'h00000000AB0080FF);
    chk("rmw dir", 64'(direccion), 64'h010);
    tick();
    chk("rmw end", {62'd0, memWr, req_ready}, 64'd1);
    chk("rmw pulses", 64'(wr_pulses - p0), 64'd1);
    load_chk("rmw readback", 13'h010, 3'd0, 2'd3, 1'b0, 64'h00000000AB0080FF);

    // Misaligned half store
    p0 = wr_pulses;
    present(1'b1, 13'h020, 3'd1, 2'd1, 1'b0, 64'h1234);
    chk("mis resp", {61'd0, resp_valid, resp_err, memWr}, 64'h6);
    chk("mis dir", 64'(direccion), 64'h010);
    chk("mis rdata", resp_rdata, 64'd0);
    tick();
    chk("mis end", {61'd0, resp_valid, resp_err, memWr}, 64'd0);
    chk("mis pulses", 64'(wr_pulses - p0), 64'd0);

    // IO region
    load_chk("io ld", 13'h1000, 3'd0, 2'd0, 1'b0, 64'h000000000000005A);
    present(1'b1, 13'h1000, 3'd2, 2'd0, 1'b0, 64'h00000000000000C3);
    chk("io st", {62'd0, memWr, resp_valid}, 64'h3);
    chk("io st data", dataWrite, 64'h00000000000000C3);
    tick();

    // Reset during the read phase of an RMW store
    p0 = wr_pulses;
    present(1'b1, 13'h010, 3'd0, 2'd0, 1'b0, 64'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort ctl", {59'd0, memWr, resp_valid, resp_err, req_ready, |resp_rdata}, 64'h2);
    chk("abort dir", 64'(direccion), 64'd0);
    chk("abort dwrite", dataWrite, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort quiet", {62'd0, memWr, resp_valid}, 64'd0);
    end
    chk("abort pulses", 64'(wr_pulses - p0), 64'd0);
    load_chk("abort mem", 13'h010, 3'd0, 2'd3, 1'b0, 64'h00000000AB0080FF);

    // READ_LAT=3 load latency
    b_addr = 13'h010; b_offset = 3'd3; b_size = 2'd0; b_signed = 1'b1; b_valid = 1'b1;
    tick();
    b_valid = 1'b0; b_addr = 13'h005; b_offset = 3'd0;
    for (int i = 1; i <= 3; i++) begin
      chk("lat3 wait", 64'(b_rvalid), 64'd0);
      tick();
    end
    chk("lat3 resp T+4", 64'(b_rvalid), 64'd1);
    chk("lat3 rdata", b_rdata, 64'hFFFFFFFFFFFFFFAB);
    tick();
    chk("lat3 end", {62'd0, b_rvalid, b_ready}, 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, meaning the number of cycles from the address being driven on direccion until dataRead is valid (legal 1..3).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, core presents an access.
REQ-005 SHALL have port req_ready, output, 1, block accepts an access this cycle.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 13, doubleword address; bit 12 = 1 selects the IO region (LEDs/switches).
REQ-008 SHALL have port req_offset, input, 3, byte offset within the doubleword.
REQ-009 SHALL have port req_size, input, 2, 00 byte, 01 half, 10 word, 11 doubleword.
REQ-010 SHALL have port req_signed, input, 1, sign-extend load result.
REQ-011 SHALL have port req_wdata, input, 64, store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata, output, 64, load result; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1, misaligned access; qualified by resp_valid.
REQ-015 SHALL have ports direccion (output, 13), dataWrite (output, 64), memWr (output, 1) and dataRead (input, 64), forming the data-memory/IO bus; all outputs registered.

Function
REQ-016 SHALL implement states IDLE, READ, WRITE and RESP; req_ready = 1 only in IDLE; an access is accepted on the edge where req_valid && req_ready (cycle T).
REQ-017 SHALL flag misalignment when req_offset is not a multiple of the size in bytes (1/2/4/8): IDLE->RESP, resp_valid=1 and resp_err=1 at T+1, with memWr never asserted and direccion unchanged.
REQ-018 SHALL handle a doubleword store or any IO-region store as IDLE->WRITE: at T+1 direccion=req_addr, dataWrite=req_wdata (IO: unshifted, low byte meaningful), memWr=1 for exactly one cycle, resp_valid=1 in that same cycle.
REQ-019 SHALL handle a load as IDLE->READ: at T+1 direccion=req_addr and memWr=0; a latency counter counts READ_LAT cycles; dataRead is sampled at the end of cycle T+READ_LAT; then RESP with resp_valid=1 at T+READ_LAT+1.
REQ-020 SHALL form the load result as dataRead shifted right by 8*req_offset and masked to the size, sign-extended from the top bit of the size when req_signed=1, else zero-extended; IO-region loads skip the shift (offset treated as 0).
REQ-021 SHALL handle a sub-doubleword memory-region store as read-modify-write: a READ phase as in REQ-019, then WRITE at T+READ_LAT+1 with dataWrite = the read data with only the addressed bytes replaced by req_wdata shifted left by 8*req_offset, memWr=1 for one cycle and resp_valid=1 in that cycle.
REQ-022 SHALL latch all request fields at acceptance; input changes during an access SHALL have no effect.
REQ-023 SHALL return to IDLE the cycle after resp_valid, so back-to-back accesses are accepted every 2 cycles minimum (stores) and every READ_LAT+2 cycles (loads).
REQ-024 SHALL hold direccion and dataWrite at their last values while idle, with memWr=0; resp_valid SHALL never be asserted except as in REQ-017..REQ-021.
REQ-025 SHALL set resp_rdata=0 whenever resp_valid=0 or the completing access is a store.

Reset
REQ-026 SHALL, while reset is high at a clock edge, force state=IDLE, direccion=0, dataWrite=0, memWr=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 from the next cycle.
REQ-027 SHALL abort any in-flight access when reset is asserted mid-operation: no memWr pulse and no resp_valid are produced for it, including an RMW caught between its READ and WRITE phases.

Verification
REQ-028 Doubleword store addr=0x005, wdata=0x1122334455667788 -> at T+1 memWr=1, direccion=0x005, dataWrite=0x1122334455667788, resp_valid=1; a subsequent load of 0x005 returns the same value at T+READ_LAT+1.
REQ-029 Memory holding 0x00000000000080FF at 0x010: load byte offset 0 signed -> 0xFFFFFFFFFFFFFFFF; half offset 0 unsigned -> 0x00000000000080FF; byte offset 1 signed -> 0xFFFFFFFFFFFFFF80.
REQ-030 RMW store byte 0xAB at offset 3 of 0x010 (holding 0x00000000000080FF) -> single memWr pulse with dataWrite=0x00000000AB0080FF; no other memWr.
REQ-031 Store half at offset 1 -> resp_valid=1, resp_err=1 at T+1, memWr stays 0; IO load addr=0x1000 with switches 0x5A -> resp_rdata=0x000000000000005A.
REQ-032 Reset asserted during the READ phase of an RMW store -> memWr never pulses, no resp_valid, all outputs 0 and req_ready=1 after the edge; repeat with READ_LAT=3 to confirm the load response arrives at T+4.
